// File: rtl/alu_writeback.sv
// alu_writeback: ALU result writeback, 32x8 register file and AVR-style SREG.
// Ports: issue_*/alu_*/stall in, rd_* read ports, sreg, wb_done, busy; macro WB_BYPASS_EN.
module alu_writeback #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] issue_rd,
  input  logic [3:0]    issue_mode,
  input  logic          issue_wb,
  input  logic [7:0]    alu_out,
  input  logic [2:0]    alu_flags,
  input  logic          stall,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [7:0]    rd_data_a,
  output logic [7:0]    rd_data_b,
  input  logic          sreg_we,
  input  logic [7:0]    sreg_wdata,
  output logic [7:0]    sreg,
  output logic          wb_done,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_rd;
  logic [3:0]    r_mode;
  logic          r_wb;
  logic [7:0]    r_res;
  logic [2:0]    r_flags;
  logic [7:0]    r_sreg;
  logic          r_wb_done;
  logic [7:0]    r_rf [NREGS];

  logic          w_commit;
  logic [7:0]    w_sreg_next;
  logic          w_n;
  logic          w_v;

  assign w_commit = (r_state == S_COMMIT) && !stall;

  // r_flags holds {Z,C,S}; moves leave SREG untouched
  always_comb begin
    w_sreg_next = r_sreg;
    w_n = r_flags[0];
    w_v = r_sreg[3];
    if (!(r_mode inside {4'b0010, 4'b0011})) begin
      if (r_mode inside {4'b0100, 4'b0101, 4'b0110})
        w_v = 1'b0;
      if (r_mode inside {4'b0000, 4'b0001, 4'b0111,
                         4'b1000, 4'b1001, 4'b1111})
        w_sreg_next[0] = r_flags[1];
      w_sreg_next[1] = r_flags[2];
      w_sreg_next[2] = w_n;
      w_sreg_next[3] = w_v;
      w_sreg_next[4] = w_n ^ w_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd      <= '0;
      r_mode    <= '0;
      r_wb      <= 1'b0;
      r_res     <= '0;
      r_flags   <= '0;
      r_sreg    <= '0;
      r_wb_done <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
    end else begin
      r_wb_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (issue_valid) begin
            r_rd    <= issue_rd;
            r_mode  <= issue_mode;
            r_wb    <= issue_wb;
            r_state <= S_SAMPLE;
          end
        end
        // ALU output settles one cycle after issue
        S_SAMPLE: begin
          r_res   <= alu_out;
          r_flags <= alu_flags;
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (w_commit) begin
            if (r_wb)
              r_rf[r_rd] <= r_res;
            r_sreg    <= w_sreg_next;
            r_wb_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // direct write overrides any flag update this cycle
      if (sreg_we)
        r_sreg <= sreg_wdata;
    end
  end

`ifdef WB_BYPASS_EN
  logic w_fwd;
  assign w_fwd = w_commit && r_wb;
  assign rd_data_a = (w_fwd && rd_addr_a == r_rd) ? r_res
                                                  : r_rf[rd_addr_a];
  assign rd_data_b = (w_fwd && rd_addr_b == r_rd) ? r_res
                                                  : r_rf[rd_addr_b];
`else
  assign rd_data_a = r_rf[rd_addr_a];
  assign rd_data_b = r_rf[rd_addr_b];
`endif

  assign sreg        = r_sreg;
  assign wb_done     = r_wb_done;
  assign busy        = (r_state != S_IDLE);
  assign issue_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed bench for alu_writeback.
// Per-cycle compare against a behavioural register/SREG model.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [4:0] issue_rd;
  logic [3:0] issue_mode;
  logic       issue_wb;
  logic [7:0] alu_out;
  logic [2:0] alu_flags;
  logic       stall;
  logic [4:0] rd_addr_a;
  logic [4:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       sreg_we;
  logic [7:0] sreg_wdata;
  logic [7:0] sreg;
  logic       wb_done;
  logic       busy;

  alu_writeback #(.NREGS(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_mode(issue_mode),
    .issue_wb(issue_wb), .alu_out(alu_out),
    .alu_flags(alu_flags), .stall(stall),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .sreg_we(sreg_we), .sreg_wdata(sreg_wdata),
    .sreg(sreg), .wb_done(wb_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rf [32];
  logic [7:0] exp_sreg;
  logic       exp_done;
  logic       exp_busy;
  logic       exp_fwd;
  logic [4:0] fwd_rd;
  logic [7:0] fwd_data;
  logic       chk_en = 1'b0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t",
               name, got, want, $time);
    end
  endtask

  // SREG rules stated per flag: which bits a mode touches
  function automatic logic [7:0] f_sreg(input logic [7:0] old,
                                        input logic [3:0] m,
                                        input logic [2:0] fl);
    logic [7:0] s;
    bit         is_move, upd_c, clr_v;
    s       = old;
    is_move = (m == 4'h2) || (m == 4'h3);
    upd_c   = (m == 4'h0) || (m == 4'h1) || (m == 4'h7) ||
              (m == 4'h8) || (m == 4'h9) || (m == 4'hF);
    clr_v   = (m == 4'h4) || (m == 4'h5) || (m == 4'h6);
    if (is_move) return old;
    s[1] = fl[2];
    s[2] = fl[0];
    if (upd_c) s[0] = fl[1];
    if (clr_v) s[3] = 1'b0;
    s[4] = s[2] ^ s[3];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) exp_rf[i] = 8'h00;
    exp_sreg = 8'h00;
    exp_done = 1'b0;
    exp_busy = 1'b0;
    exp_fwd  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] ea, eb;
      ea = (exp_fwd && rd_addr_a == fwd_rd) ? fwd_data
                                            : exp_rf[rd_addr_a];
      eb = (exp_fwd && rd_addr_b == fwd_rd) ? fwd_data
                                            : exp_rf[rd_addr_b];
      check("sreg", sreg, exp_sreg);
      check("wb_done", {7'd0, wb_done}, {7'd0, exp_done});
      check("busy", {7'd0, busy}, {7'd0, exp_busy});
      check("issue_ready", {7'd0, issue_ready}, {7'd0, !exp_busy});
      check("rd_data_a", rd_data_a, ea);
      check("rd_data_b", rd_data_b, eb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [4:0] rd,
                    input logic [3:0] m,
                    input logic       wb,
                    input logic [7:0] res,
                    input logic [2:0] fl,
                    input int         nstall,
                    input logic       swe,
                    input logic [7:0] swd,
                    input logic       abort,
                    input int         fwd_pin);
    tick();
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_mode  = m;
    issue_wb    = wb;
    alu_out     = 8'hEE;
    alu_flags   = ~fl;
    rd_addr_a   = rd;
    tick();
    exp_busy   = 1'b1;
    issue_rd   = 5'd31;
    issue_mode = 4'h0;
    issue_wb   = 1'b1;
    alu_out    = res;
    alu_flags  = fl;
    if (abort) begin
      rst = 1'b1;
      tick();
      rst         = 1'b0;
      issue_valid = 1'b0;
      model_reset();
      return;
    end
    tick();
    alu_out   = 8'hC3;
    alu_flags = ~fl;
    stall     = (nstall > 0);
    for (int i = 0; i < nstall; i++) begin
      tick();
      if (i == nstall - 1) stall = 1'b0;
    end
    exp_fwd    = BYP && wb;
    fwd_rd     = rd;
    fwd_data   = res;
    sreg_we    = swe;
    sreg_wdata = swd;
    if (fwd_pin >= 0) begin
      #1;
      check("fwd_pin", rd_data_a, fwd_pin[7:0]);
    end
    tick();
    exp_fwd = 1'b0;
    if (wb) exp_rf[rd] = res;
    exp_sreg    = swe ? swd : f_sreg(exp_sreg, m, fl);
    exp_done    = 1'b1;
    exp_busy    = 1'b0;
    sreg_we     = 1'b0;
    issue_valid = 1'b0;
    tick();
    exp_done = 1'b0;
  endtask

  task automatic sreg_write(input logic [7:0] d);
    tick();
    sreg_we    = 1'b1;
    sreg_wdata = d;
    tick();
    sreg_we  = 1'b0;
    exp_sreg = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_mode  = '0;
    issue_wb    = 1'b0;
    alu_out     = '0;
    alu_flags   = '0;
    stall       = 1'b0;
    rd_addr_a   = 5'd5;
    rd_addr_b   = 5'd9;
    sreg_we     = 1'b0;
    sreg_wdata  = '0;
    fwd_rd      = '0;
    fwd_data    = '0;
    model_reset();
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    op(5, 4'h0, 1, 8'h00, 3'b110, 0, 0, 8'h00, 0, -1);
    check("pin_sreg_op1", sreg, 8'h03);

    sreg_write(8'h09);
    op(7, 4'h4, 1, 8'h80, 3'b001, 0, 0, 8'h00, 0, -1);
    check("pin_sreg_op2", sreg, 8'h15);
    check("pin_r7", rd_data_a, 8'h80);

    op(3, 4'h2, 1, 8'h7F, 3'b111, 0, 0, 8'h00, 0, -1);
    check("pin_sreg_move", sreg, 8'h15);
    check("pin_r3", rd_data_a, 8'h7F);

    op(9, 4'h8, 1, 8'h42, 3'b000, 4, 0, 8'h00, 0, -1);
    check("pin_sreg_stall", sreg, 8'h00);
    check("pin_r9", rd_data_a, 8'h42);

    op(9, 4'h5, 1, 8'hA5, 3'b100, 0, 0, 8'h00, 0,
       BYP ? 32'hA5 : 32'h42);
    check("pin_sreg_op5", sreg, 8'h02);
    check("pin_r9_new", rd_data_a, 8'hA5);

    op(3, 4'h1, 0, 8'h11, 3'b010, 0, 0, 8'h00, 0, -1);
    check("pin_sreg_cmp", sreg, 8'h01);
    check("pin_r3_kept", rd_data_a, 8'h7F);

    op(4, 4'h0, 1, 8'h5A, 3'b000, 0, 1, 8'hFF, 0, -1);
    check("pin_sreg_we", sreg, 8'hFF);
    check("pin_r4", rd_data_a, 8'h5A);

    op(6, 4'h0, 1, 8'h33, 3'b110, 0, 0, 8'h00, 1, -1);
    tick();
    tick();
    check("pin_sreg_abort", sreg, 8'h00);
    check("pin_r6_abort", rd_data_a, 8'h00);

    op(6, 4'h9, 1, 8'h81, 3'b001, 0, 0, 8'h00, 0, -1);
    check("pin_sreg_op9", sreg, 8'h14);
    check("pin_r6", rd_data_a, 8'h81);

    for (int i = 0; i < 32; i++) begin
      tick();
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
    end
    tick();
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
